boc_acq_search: RTL and testbench

BOC_ACQ_SEARCH -- requirements
Module: boc_acq_search

---
 rtl/boc_acq_search.sv | 272 +++++++++++++++++++++++++++
 tb/tb_boc_acq_search.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boc_acq_search.sv
// -----------------------------------------------------------------------------
// boc_acq_search
//
// Purpose:
//   Code-phase / Doppler acquisition search controller for a BOC receiver.
//   A sweep collects the strongest correlation magnitude (and its code phase)
//   and a coarse noise floor over one full code period. At the end of each
//   sweep the peak is compared against floor << rx_thr_shift. If the peak
//   passes, the block waits for the tracking code generator to reach the
//   alignment phase and pulses tx_trk_rst. If it misses, the next Doppler bin
//   is searched, and after the last bin the search fails.
//
// Optional feature (compile-time macro):
//   BOC_ACQ_CONFIRM_EN - a pass must be confirmed by a second sweep in the
//                        same bin that yields the identical peak phase. A
//                        confirmation mismatch is treated as a miss.
//
// Ports:
//   rx_clk        in   sole clock, rising edge
//   rx_rst        in   synchronous active-high reset
//   rx_start      in   one-cycle pulse, starts a search from bin 0
//                      (honoured only in IDLE, LOCKED and FAIL)
//   rx_corr_vld   in   strobe qualifying rx_corr_acc / rx_corr_phs
//   rx_corr_acc   in   N_CH packed magnitudes, lane 0 in the LSBs
//   rx_corr_phs   in   N_CH packed code phases, lane 0 in the LSBs
//   rx_thr_shift  in   detection threshold exponent
//   rx_trk_phs    in   current phase of the tracking code generator
//   tx_bin_idx    out  Doppler bin under search
//   tx_acq_phs    out  alignment phase, CODE_LEN-1 minus peak phase
//   tx_peak       out  sweep peak magnitude
//   tx_floor      out  sweep noise-floor accumulator
//   tx_trk_rst    out  one-cycle tracking-loop reset (also high during rx_rst)
//   tx_acq_suc    out  acquisition succeeded (level)
//   tx_acq_fail   out  all bins searched without detection (level)
//   tx_busy       out  high in SWEEP, DECIDE and ALIGN
// -----------------------------------------------------------------------------
module boc_acq_search #(
    parameter int N_CH      = 4,
    parameter int ACC_WIDTH = 48,
    parameter int PHS_WIDTH = 12,
    parameter int CODE_LEN  = 4092,
    parameter int N_BINS    = 8,
    parameter int AVG_SHIFT = 12,
    localparam int BIN_W    = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
    input  logic                      rx_clk,
    input  logic                      rx_rst,
    input  logic                      rx_start,
    input  logic                      rx_corr_vld,
    input  logic [N_CH*ACC_WIDTH-1:0] rx_corr_acc,
    input  logic [N_CH*PHS_WIDTH-1:0] rx_corr_phs,
    input  logic [3:0]                rx_thr_shift,
    input  logic [PHS_WIDTH-1:0]      rx_trk_phs,
    output logic [BIN_W-1:0]          tx_bin_idx,
    output logic [PHS_WIDTH-1:0]      tx_acq_phs,
    output logic [ACC_WIDTH-1:0]      tx_peak,
    output logic [ACC_WIDTH-1:0]      tx_floor,
    output logic                      tx_trk_rst,
    output logic                      tx_acq_suc,
    output logic                      tx_acq_fail,
    output logic                      tx_busy
);

    // Per-strobe floor increment needs log2(N_CH) extra bits; one more bit
    // on top catches the carry out of floor + increment for saturation.
    localparam int SUM_W = ACC_WIDTH + $clog2(N_CH) + 1;
    // Threshold compare width: floor << 15 can never overflow this.
    localparam int CMP_W = ACC_WIDTH + 16;

    localparam logic [PHS_WIDTH-1:0] LAST_PHS  = PHS_WIDTH'(CODE_LEN - 1);
    localparam logic [BIN_W-1:0]     LAST_BIN  = BIN_W'(N_BINS - 1);
    localparam logic [SUM_W:0]       FLOOR_MAX = (SUM_W + 1)'({ACC_WIDTH{1'b1}});

    typedef enum logic [2:0] {
        IDLE,
        SWEEP,
        DECIDE,
        ALIGN,
        LOCKED,
        FAIL
    } state_t;

    state_t                 state_q,    state_d;
    logic [BIN_W-1:0]       bin_q,      bin_d;
    logic [ACC_WIDTH-1:0]   peak_q,     peak_d;
    logic [PHS_WIDTH-1:0]   peak_phs_q, peak_phs_d;
    logic [ACC_WIDTH-1:0]   floor_q,    floor_d;
    logic [PHS_WIDTH-1:0]   acq_phs_q,  acq_phs_d;
    logic                   suc_q,      suc_d;
    logic                   fail_q,     fail_d;
    logic                   trk_rst_q,  trk_rst_d;
`ifdef BOC_ACQ_CONFIRM_EN
    logic                   conf_pend_q, conf_pend_d;
    logic [PHS_WIDTH-1:0]   conf_phs_q,  conf_phs_d;
`endif

    // Datapath: strongest lane of the current strobe, floor increment,
    // saturated floor, threshold test and end-of-sweep detection.
    logic [ACC_WIDTH-1:0]   best_acc;
    logic [PHS_WIDTH-1:0]   best_phs;
    logic [SUM_W-1:0]       lane_sum;
    logic [SUM_W:0]         floor_sum;
    logic [ACC_WIDTH-1:0]   floor_nxt;
    logic                   detect;
    logic                   end_of_sweep;
    logic                   miss;

    always_comb begin
        best_acc = '0;
        best_phs = '0;
        lane_sum = '0;
        // Strict '>' while scanning upward keeps the lowest lane on a tie.
        for (int i = 0; i < N_CH; i++) begin
            if (rx_corr_acc[i*ACC_WIDTH +: ACC_WIDTH] > best_acc) begin
                best_acc = rx_corr_acc[i*ACC_WIDTH +: ACC_WIDTH];
                best_phs = rx_corr_phs[i*PHS_WIDTH +: PHS_WIDTH];
            end
            lane_sum = lane_sum + SUM_W'(rx_corr_acc[i*ACC_WIDTH +: ACC_WIDTH] >> AVG_SHIFT);
        end
        floor_sum = (SUM_W + 1)'(floor_q) + (SUM_W + 1)'(lane_sum);
        floor_nxt = (floor_sum > FLOOR_MAX) ? {ACC_WIDTH{1'b1}} : floor_sum[ACC_WIDTH-1:0];
        detect    = CMP_W'(peak_q) > (CMP_W'(floor_q) << rx_thr_shift);
        end_of_sweep = rx_corr_phs[(N_CH-1)*PHS_WIDTH +: PHS_WIDTH] == LAST_PHS;
    end

    // Next-state and register-update logic.
    always_comb begin
        // NOTE: every _d gets its hold value before the case, so no path
        // through this block can leave a signal unassigned and infer a latch.
        state_d    = state_q;
        bin_d      = bin_q;
        peak_d     = peak_q;
        peak_phs_d = peak_phs_q;
        floor_d    = floor_q;
        acq_phs_d  = acq_phs_q;
        suc_d      = suc_q;
        fail_d     = fail_q;
        trk_rst_d  = 1'b0;
        miss       = 1'b0;
`ifdef BOC_ACQ_CONFIRM_EN
        conf_pend_d = conf_pend_q;
        conf_phs_d  = conf_phs_q;
`endif

        case (state_q)
            IDLE, LOCKED, FAIL: begin
                if (rx_start) begin
                    state_d    = SWEEP;
                    bin_d      = '0;
                    peak_d     = '0;
                    peak_phs_d = '0;
                    floor_d    = '0;
                    suc_d      = 1'b0;
                    fail_d     = 1'b0;
`ifdef BOC_ACQ_CONFIRM_EN
                    conf_pend_d = 1'b0;
`endif
                end
            end

            SWEEP: begin
                if (rx_corr_vld) begin
                    // Strict '>' keeps the earlier strobe on a tie.
                    if (best_acc > peak_q) begin
                        peak_d     = best_acc;
                        peak_phs_d = best_phs;
                    end
                    floor_d = floor_nxt;
                    if (end_of_sweep) begin
                        state_d = DECIDE;
                    end
                end
            end

            DECIDE: begin
`ifdef BOC_ACQ_CONFIRM_EN
                if (detect && !conf_pend_q) begin
                    // First pass in this bin: repeat the bin and remember the
                    // phase the confirmation sweep has to reproduce.
                    conf_pend_d = 1'b1;
                    conf_phs_d  = peak_phs_q;
                    peak_d      = '0;
                    peak_phs_d  = '0;
                    floor_d     = '0;
                    state_d     = SWEEP;
                end else if (detect && (peak_phs_q == conf_phs_q)) begin
                    conf_pend_d = 1'b0;
                    acq_phs_d   = LAST_PHS - peak_phs_q;
                    state_d     = ALIGN;
                end else begin
                    conf_pend_d = 1'b0;
                    miss        = 1'b1;
                end
`else
                if (detect) begin
                    acq_phs_d = LAST_PHS - peak_phs_q;
                    state_d   = ALIGN;
                end else begin
                    miss = 1'b1;
                end
`endif
                if (miss) begin
                    if (bin_q < LAST_BIN) begin
                        bin_d      = bin_q + BIN_W'(1);
                        peak_d     = '0;
                        peak_phs_d = '0;
                        floor_d    = '0;
                        state_d    = SWEEP;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = FAIL;
                    end
                end
            end

            ALIGN: begin
                if (rx_trk_phs == acq_phs_q) begin
                    trk_rst_d = 1'b1;
                    suc_d     = 1'b1;
                    state_d   = LOCKED;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of every other flop, independent of statement order.
        if (rx_rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            peak_q     <= '0;
            peak_phs_q <= '0;
            floor_q    <= '0;
            acq_phs_q  <= '0;
            suc_q      <= 1'b0;
            fail_q     <= 1'b0;
            trk_rst_q  <= 1'b0;
`ifdef BOC_ACQ_CONFIRM_EN
            conf_pend_q <= 1'b0;
            conf_phs_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            peak_q     <= peak_d;
            peak_phs_q <= peak_phs_d;
            floor_q    <= floor_d;
            acq_phs_q  <= acq_phs_d;
            suc_q      <= suc_d;
            fail_q     <= fail_d;
            trk_rst_q  <= trk_rst_d;
`ifdef BOC_ACQ_CONFIRM_EN
            conf_pend_q <= conf_pend_d;
            conf_phs_q  <= conf_phs_d;
`endif
        end
    end

    assign tx_bin_idx  = bin_q;
    assign tx_acq_phs  = acq_phs_q;
    assign tx_peak     = peak_q;
    assign tx_floor    = floor_q;
    // Tracking loop is held in reset for as long as this block is.
    assign tx_trk_rst  = trk_rst_q | rx_rst;
    assign tx_acq_suc  = suc_q;
    assign tx_acq_fail = fail_q;
    assign tx_busy     = (state_q == SWEEP) || (state_q == DECIDE) || (state_q == ALIGN);

endmodule

// File: tb/tb_boc_acq_search.sv
// -----------------------------------------------------------------------------
// tb_boc_acq_search
//
// Directed bench for boc_acq_search at default parameters. Each sweep is
// driven as CODE_LEN/N_CH strobes, lane l of strobe k carrying phase
// k*N_CH+l and a base magnitude, with optional "spikes" that replace the
// magnitude and phase of one lane of one strobe. While a sweep is driven a
// reference model derives the expected peak, floor, bin and decision and
// pushes them to a scoreboard queue; the record is popped and compared
// when the DUT reaches DECIDE and again one cycle later for the outcome.
// Define BOC_ACQ_CONFIRM_EN for the bench as well as the RTL to cover the
// confirmation-sweep build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_boc_acq_search;

    localparam int N_CH      = 4;
    localparam int ACC_WIDTH = 48;
    localparam int PHS_WIDTH = 12;
    localparam int CODE_LEN  = 4092;
    localparam int N_BINS    = 8;
    localparam int AVG_SHIFT = 12;
    localparam int BIN_W     = 3;
    localparam int N_STROBES = CODE_LEN / N_CH;
    localparam logic [63:0] FLOOR_MAX = 64'h0000_FFFF_FFFF_FFFF;
`ifdef BOC_ACQ_CONFIRM_EN
    localparam bit CONFIRM = 1'b1;
`else
    localparam bit CONFIRM = 1'b0;
`endif

    localparam int K_ALIGN   = 0;
    localparam int K_CONFIRM = 1;
    localparam int K_MISS    = 2;
    localparam int K_FAIL    = 3;

    typedef struct {
        int                   strobe;
        int                   lane;
        logic [ACC_WIDTH-1:0] acc;
        int                   phs;
    } spike_t;

    typedef struct {
        logic [63:0] peak;
        logic [63:0] floor;
        int          bin;
        int          kind;
        int          acq_phs;
    } exp_t;

    logic                      rx_clk = 1'b0;
    logic                      rx_rst;
    logic                      rx_start;
    logic                      rx_corr_vld;
    logic [N_CH*ACC_WIDTH-1:0] rx_corr_acc;
    logic [N_CH*PHS_WIDTH-1:0] rx_corr_phs;
    logic [3:0]                rx_thr_shift;
    logic [PHS_WIDTH-1:0]      rx_trk_phs;
    logic [BIN_W-1:0]          tx_bin_idx;
    logic [PHS_WIDTH-1:0]      tx_acq_phs;
    logic [ACC_WIDTH-1:0]      tx_peak;
    logic [ACC_WIDTH-1:0]      tx_floor;
    logic                      tx_trk_rst;
    logic                      tx_acq_suc;
    logic                      tx_acq_fail;
    logic                      tx_busy;

    boc_acq_search dut (
        .rx_clk       (rx_clk),
        .rx_rst       (rx_rst),
        .rx_start     (rx_start),
        .rx_corr_vld  (rx_corr_vld),
        .rx_corr_acc  (rx_corr_acc),
        .rx_corr_phs  (rx_corr_phs),
        .rx_thr_shift (rx_thr_shift),
        .rx_trk_phs   (rx_trk_phs),
        .tx_bin_idx   (tx_bin_idx),
        .tx_acq_phs   (tx_acq_phs),
        .tx_peak      (tx_peak),
        .tx_floor     (tx_floor),
        .tx_trk_rst   (tx_trk_rst),
        .tx_acq_suc   (tx_acq_suc),
        .tx_acq_fail  (tx_acq_fail),
        .tx_busy      (tx_busy)
    );

    always #5 rx_clk = ~rx_clk;

    int     n_checks = 0;
    int     n_errors = 0;
    int     trk_pulses = 0;
    int     exp_pulses = 0;
    exp_t   sb_q[$];
    spike_t spk[$];

    // Reference-model search state.
    int     m_bin;
    bit     m_pend;
    int     m_conf_phs;

    // Counts tracking resets issued by the acquisition, not by rx_rst.
    always @(negedge rx_clk) begin
        if (!rx_rst && tx_trk_rst) trk_pulses++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_spike(input int s, input int l, input logic [ACC_WIDTH-1:0] a, input int p);
        spike_t sp;
        sp.strobe = s;
        sp.lane   = l;
        sp.acc    = a;
        sp.phs    = p;
        spk.push_back(sp);
    endtask

    task automatic start_search();
        @(negedge rx_clk);
        rx_start = 1'b1;
        @(negedge rx_clk);
        rx_start = 1'b0;
        m_bin  = 0;
        m_pend = 1'b0;
        check("start_busy",  tx_busy,     1);
        check("start_bin",   tx_bin_idx,  0);
        check("start_peak",  tx_peak,     0);
        check("start_floor", tx_floor,    0);
        check("start_suc",   tx_acq_suc,  0);
        check("start_fail",  tx_acq_fail, 0);
    endtask

    // Drives n_str strobes. start_at / rst_at raise rx_start / rx_rst together
    // with that strobe (-1 = never). A sweep cut short by reset pushes nothing.
    task automatic sweep(input logic [ACC_WIDTH-1:0] base, input int n_str,
                         input int start_at, input int rst_at);
        logic [63:0] m_peak;
        logic [63:0] m_floor;
        int          m_phs;
        exp_t        e;
        m_peak  = '0;
        m_floor = '0;
        m_phs   = 0;
        for (int k = 0; k < n_str; k++) begin
            logic [ACC_WIDTH-1:0] a;
            int                   p;
            logic [63:0]          ssum;
            @(negedge rx_clk);
            ssum = '0;
            for (int l = 0; l < N_CH; l++) begin
                a = base;
                p = k * N_CH + l;
                foreach (spk[s]) begin
                    if (spk[s].strobe == k && spk[s].lane == l) begin
                        a = spk[s].acc;
                        p = spk[s].phs;
                    end
                end
                rx_corr_acc[l*ACC_WIDTH +: ACC_WIDTH] = a;
                rx_corr_phs[l*PHS_WIDTH +: PHS_WIDTH] = PHS_WIDTH'(p);
                if (64'(a) > m_peak) begin
                    m_peak = 64'(a);
                    m_phs  = p;
                end
                ssum = ssum + 64'(a >> AVG_SHIFT);
            end
            m_floor = m_floor + ssum;
            if (m_floor > FLOOR_MAX) m_floor = FLOOR_MAX;
            rx_corr_vld = 1'b1;
            rx_start    = (k == start_at);
            rx_rst      = (k == rst_at);
        end
        if (rst_at < 0) begin
            e.peak    = m_peak;
            e.floor   = m_floor;
            e.bin     = m_bin;
            e.acq_phs = 0;
            if (m_peak > (m_floor << rx_thr_shift) && CONFIRM && !m_pend) begin
                e.kind     = K_CONFIRM;
                m_pend     = 1'b1;
                m_conf_phs = m_phs;
            end else if (m_peak > (m_floor << rx_thr_shift) && (!CONFIRM || m_conf_phs == m_phs)) begin
                e.kind    = K_ALIGN;
                e.acq_phs = CODE_LEN - 1 - m_phs;
                m_pend    = 1'b0;
            end else begin
                m_pend = 1'b0;
                if (m_bin < N_BINS - 1) begin
                    e.kind = K_MISS;
                    m_bin++;
                end else begin
                    e.kind = K_FAIL;
                end
            end
            sb_q.push_back(e);
        end
    endtask

    // Called right after sweep(): first negedge is the DECIDE cycle, the
    // second shows the decision outcome.
    task automatic decide_check(output int kind);
        exp_t e;
        @(negedge rx_clk);
        rx_corr_vld = 1'b0;
        rx_start    = 1'b0;
        e = sb_q.pop_front();
        kind = e.kind;
        check("dec_peak",  tx_peak,    e.peak);
        check("dec_floor", tx_floor,   e.floor);
        check("dec_bin",   tx_bin_idx, 64'(e.bin));
        check("dec_busy",  tx_busy,    1);
        @(negedge rx_clk);
        case (e.kind)
            K_ALIGN: begin
                check("pass_acq_phs", tx_acq_phs, 64'(e.acq_phs));
                check("pass_busy",    tx_busy,    1);
                check("pass_suc",     tx_acq_suc, 0);
                check("pass_bin",     tx_bin_idx, 64'(e.bin));
            end
            K_CONFIRM, K_MISS: begin
                check("resweep_bin",   tx_bin_idx, 64'(e.kind == K_MISS ? e.bin + 1 : e.bin));
                check("resweep_peak",  tx_peak,    0);
                check("resweep_floor", tx_floor,   0);
                check("resweep_busy",  tx_busy,    1);
            end
            default: begin
                check("fail_flag",  tx_acq_fail, 1);
                check("fail_busy",  tx_busy,     0);
                check("fail_bin",   tx_bin_idx,  64'(e.bin));
                check("fail_peak",  tx_peak,     e.peak);
                check("fail_floor", tx_floor,    e.floor);
            end
        endcase
    endtask

    // Repeats the sweep while the decision asks for confirmation.
    task automatic full_sweep(input logic [ACC_WIDTH-1:0] base, input int start_at);
        int kind;
        do begin
            sweep(base, N_STROBES, start_at, -1);
            decide_check(kind);
        end while (kind == K_CONFIRM);
    endtask

    task automatic align(input int phs);
        @(negedge rx_clk);
        rx_trk_phs = PHS_WIDTH'(phs - 1);
        @(negedge rx_clk);
        check("align_early_trk_rst", tx_trk_rst, 0);
        check("align_wait_busy",     tx_busy,    1);
        rx_trk_phs = PHS_WIDTH'(phs);
        @(negedge rx_clk);
        exp_pulses++;
        check("lock_trk_rst", tx_trk_rst, 1);
        check("lock_suc",     tx_acq_suc, 1);
        check("lock_busy",    tx_busy,    0);
        check("lock_acq_phs", tx_acq_phs, 64'(phs));
        @(negedge rx_clk);
        check("lock_trk_rst_single", tx_trk_rst, 0);
        check("lock_pulse_count",    64'(trk_pulses), 64'(exp_pulses));
        rx_trk_phs = '0;
    endtask

    initial begin
        int kind;
        rx_rst       = 1'b1;
        rx_start     = 1'b0;
        rx_corr_vld  = 1'b0;
        rx_corr_acc  = '0;
        rx_corr_phs  = '0;
        rx_thr_shift = 4'd4;
        rx_trk_phs   = '0;
        m_bin        = 0;
        m_pend       = 1'b0;
        m_conf_phs   = 0;

        // Reset state.
        repeat (3) @(negedge rx_clk);
        check("rst_trk_rst_high", tx_trk_rst, 1);
        check("rst_busy",         tx_busy,    0);
        rx_rst = 1'b0;
        @(negedge rx_clk);
        check("rst_trk_rst_low", tx_trk_rst,  0);
        check("rst_bin",         tx_bin_idx,  0);
        check("rst_acq_phs",     tx_acq_phs,  0);
        check("rst_peak",        tx_peak,     0);
        check("rst_floor",       tx_floor,    0);
        check("rst_suc",         tx_acq_suc,  0);
        check("rst_fail",        tx_acq_fail, 0);

        // Strong peak at lane 2, phase 100 -> align at 3991.
        start_search();
        spk.delete();
        add_spike(25, 2, 48'h10000, 100);
        full_sweep(48'h100, -1);
        align(3991);

        // Correlator strobes are ignored once locked.
        @(negedge rx_clk);
        rx_corr_acc = '1;
        rx_corr_phs = {PHS_WIDTH'(CODE_LEN - 1), PHS_WIDTH'(0), PHS_WIDTH'(0), PHS_WIDTH'(0)};
        rx_corr_vld = 1'b1;
        @(negedge rx_clk);
        rx_corr_vld = 1'b0;
        @(negedge rx_clk);
        check("locked_peak_hold",  tx_peak,    48'h10000);
        check("locked_floor_hold", tx_floor,   16);
        check("locked_busy",       tx_busy,    0);
        check("locked_suc_hold",   tx_acq_suc, 1);

        // Equal peaks on lanes 1 and 3 of one strobe, plus an equal one in a
        // later strobe: lane 1 of the first strobe wins -> 4091-20.
        start_search();
        spk.delete();
        add_spike(5, 1, 48'h8000, 20);
        add_spike(5, 3, 48'h8000, 22);
        add_spike(50, 0, 48'h8000, 200);
        full_sweep(48'h0, -1);
        align(4071);

        // Flat magnitudes never detect: all bins then FAIL. An rx_start
        // during the bin-3 sweep must be ignored.
        start_search();
        spk.delete();
        for (int b = 0; b < N_BINS; b++) begin
            full_sweep(48'h1000, (b == 3) ? 500 : -1);
        end
        check("fail_no_trk_rst", 64'(trk_pulses), 64'(exp_pulses));

        // Reset in the middle of a sweep, at the strobe carrying phase 2000.
        start_search();
        sweep(48'h1000, 501, -1, 500);
        @(negedge rx_clk);
        rx_corr_vld = 1'b0;
        check("midrst_trk_rst_high", tx_trk_rst,  1);
        check("midrst_busy",         tx_busy,     0);
        check("midrst_bin",          tx_bin_idx,  0);
        check("midrst_peak",         tx_peak,     0);
        check("midrst_floor",        tx_floor,    0);
        check("midrst_acq_phs",      tx_acq_phs,  0);
        check("midrst_suc",          tx_acq_suc,  0);
        check("midrst_fail",         tx_acq_fail, 0);
        rx_rst = 1'b0;
        @(negedge rx_clk);
        check("midrst_trk_rst_low", tx_trk_rst, 0);
        check("midrst_idle_busy",   tx_busy,    0);
        start_search();
        spk.delete();
        add_spike(25, 2, 48'h10000, 100);
        full_sweep(48'h100, -1);
        align(3991);

        // Threshold boundary: peak equal to floor<<thr misses, one shift
        // lower passes.
        start_search();
        spk.delete();
        add_spike(10, 1, 48'h10000, 41);
        rx_thr_shift = 4'd12;
        full_sweep(48'h0, -1);
        rx_thr_shift = 4'd11;
        full_sweep(48'h0, -1);
        align(4050);
        rx_thr_shift = 4'd4;

`ifdef BOC_ACQ_CONFIRM_EN
        // Confirmation sweep lands on a different phase -> miss, next bin.
        start_search();
        spk.delete();
        add_spike(25, 2, 48'h10000, 100);
        sweep(48'h100, N_STROBES, -1, -1);
        decide_check(kind);
        spk.delete();
        add_spike(25, 2, 48'h10000, 101);
        sweep(48'h100, N_STROBES, -1, -1);
        decide_check(kind);
        check("confirm_no_suc",    tx_acq_suc, 0);
        check("confirm_no_pulse",  64'(trk_pulses), 64'(exp_pulses));
`else
        kind = 0;
`endif

        @(negedge rx_clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
